uart_rx_ctrl: RTL and testbench

//  Receive-side controller for uart_rx. Sequences its active-low read

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 65 ++++++
 rtl/uart_rx_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the uart_rx receive path: error-flag bundle, controller
// state encoding and status-counter slot indices.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef struct packed {
    logic overrun;
    logic framing;
    logic parity;
  } uart_err_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    ACK
  } rx_ctrl_state_t;

  // Slot order of the saturating status counters
  localparam int CNT_PARITY  = 0;
  localparam int CNT_FRAMING = 1;
  localparam int CNT_OVERRUN = 2;
  localparam int CNT_DROP    = 3;
  localparam int CNT_NUM     = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered head entry and an occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic                         push_ok_o,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Head is a synchronous read of the next read slot; a write landing in that
  // same slot is forwarded so a push into an empty FIFO is visible next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (count_d != '0) begin
        head_q <= (push_ok && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
      end
    end
  end

  assign push_ok_o = push_ok;
  assign rdata_o   = head_q;
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for uart_rx: acknowledges each byte with an active-low
// read pulse, queues byte+flags in a FIFO and keeps saturating status counters.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                         mclkx16,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [UART_DATA_W-1:0]       rx_rdata,
  input  logic                         rx_rxrdy,
  input  logic                         rx_parityerr,
  input  logic                         rx_framingerr,
  input  logic                         rx_overrun,
  output logic                         rx_read,
  output logic [UART_DATA_W-1:0]       m_data,
  output logic [2:0]                   m_err,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [CNT_W-1:0]             cnt_parity,
  output logic [CNT_W-1:0]             cnt_framing,
  output logic [CNT_W-1:0]             cnt_overrun,
  output logic [CNT_W-1:0]             cnt_drop,
  output logic                         ack_timeout,
  input  logic                         clr_cnt
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int EW = UART_DATA_W + $bits(uart_err_t);

  rx_ctrl_state_t   state_q, state_d;
  logic             rx_read_q, rx_read_d;
  logic             timeout_q, timeout_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_NUM-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_q [CNT_NUM];
  logic [CNT_W-1:0] cnt_d [CNT_NUM];
  logic             push, push_ok;
  uart_err_t        rx_err;
  logic [EW-1:0]    head;

  assign rx_err.overrun = rx_overrun;
  assign rx_err.framing = rx_framingerr;
  assign rx_err.parity  = rx_parityerr;

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (mclkx16),
    .rst_ni    (reset),
    .push_i    (push),
    .wdata_i   ({rx_err, rx_rdata}),
    .push_ok_o (push_ok),
    .pop_i     (m_ready),
    .rdata_o   (head),
    .valid_o   (m_valid),
    .count_o   (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    rx_read_d = rx_read_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    push      = 1'b0;
    cnt_inc   = '0;
    unique case (state_q)
      IDLE: begin
        rx_read_d = 1'b1;
        timer_d   = '0;
        if (enable && rx_rxrdy) state_d = CAPTURE;
      end
      CAPTURE: begin
        push                 = 1'b1;
        cnt_inc[CNT_PARITY]  = rx_parityerr;
        cnt_inc[CNT_FRAMING] = rx_framingerr;
        cnt_inc[CNT_OVERRUN] = rx_overrun;
        cnt_inc[CNT_DROP]    = !push_ok;
        rx_read_d            = 1'b0;
        timer_d              = '0;
        state_d              = ACK;
      end
      ACK: begin
        // The ACK cycle count is bounded so a stuck rxrdy cannot hold rx_read low forever
        if (!rx_rxrdy) begin
          state_d   = IDLE;
          rx_read_d = 1'b1;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d   = IDLE;
          rx_read_d = 1'b1;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        rx_read_d = 1'b1;
      end
    endcase
    if (clr_cnt) timeout_d = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < CNT_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt) begin
        cnt_d[i] = '0;
      end else if (cnt_inc[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rx_read_q <= 1'b1;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < CNT_NUM; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rx_read_q <= rx_read_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      for (int i = 0; i < CNT_NUM; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rx_read     = rx_read_q;
  assign m_data      = head[UART_DATA_W-1:0];
  assign m_err       = head[EW-1:UART_DATA_W];
  assign ack_timeout = timeout_q;
  assign cnt_parity  = cnt_q[CNT_PARITY];
  assign cnt_framing = cnt_q[CNT_FRAMING];
  assign cnt_overrun = cnt_q[CNT_OVERRUN];
  assign cnt_drop    = cnt_q[CNT_DROP];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a behavioural uart_rx stand-in drives frames, and a
// queue-based model predicts popped entries, counters and ACK timing.
module tb_uart_rx_ctrl;

  localparam int DEPTH       = 8;
  localparam int CNT_W       = 8;
  localparam int ACK_TIMEOUT = 64;
  localparam int CW          = $clog2(DEPTH + 1);
  localparam int CNT_MAX     = 2**CNT_W - 1;

  logic             mclkx16 = 1'b0;
  logic             reset;
  logic             enable;
  logic [7:0]       rx_rdata;
  logic             rx_rxrdy, rx_parityerr, rx_framingerr, rx_overrun;
  logic             rx_read;
  logic [7:0]       m_data;
  logic [2:0]       m_err;
  logic             m_valid;
  logic             m_ready;
  logic [CW-1:0]    fifo_count;
  logic [CNT_W-1:0] cnt_parity, cnt_framing, cnt_overrun, cnt_drop;
  logic             ack_timeout;
  logic             clr_cnt;

  always #5 mclkx16 = ~mclkx16;

  uart_rx_ctrl #(
    .DEPTH       (DEPTH),
    .CNT_W       (CNT_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .mclkx16       (mclkx16),
    .reset         (reset),
    .enable        (enable),
    .rx_rdata      (rx_rdata),
    .rx_rxrdy      (rx_rxrdy),
    .rx_parityerr  (rx_parityerr),
    .rx_framingerr (rx_framingerr),
    .rx_overrun    (rx_overrun),
    .rx_read       (rx_read),
    .m_data        (m_data),
    .m_err         (m_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fifo_count    (fifo_count),
    .cnt_parity    (cnt_parity),
    .cnt_framing   (cnt_framing),
    .cnt_overrun   (cnt_overrun),
    .cnt_drop      (cnt_drop),
    .ack_timeout   (ack_timeout),
    .clr_cnt       (clr_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] pop_log[$];
  int m_par, m_fra, m_ovr, m_drop;
  int m_tmo;

  always @(posedge mclkx16) begin
    if (reset && m_valid && m_ready) pop_log.push_back({m_err, m_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_cnt_parity"},  cnt_parity,  m_par);
    check({tag, "_cnt_framing"}, cnt_framing, m_fra);
    check({tag, "_cnt_overrun"}, cnt_overrun, m_ovr);
    check({tag, "_cnt_drop"},    cnt_drop,    m_drop);
    check({tag, "_ack_timeout"}, ack_timeout, m_tmo);
  endtask

  task automatic clear_model();
    m_par = 0; m_fra = 0; m_ovr = 0; m_drop = 0; m_tmo = 0;
  endtask

  // One frame through the uart_rx stand-in; f = {overrun, framing, parity}
  task automatic send(input logic [7:0] d, input logic [2:0] f, input bit ignore_read,
                      input bit clr_cap, output int low_cycles);
    int occ;
    int lat;
    @(negedge mclkx16);
    occ = exp_q.size() - pop_log.size();
    rx_rdata = d;
    {rx_overrun, rx_framingerr, rx_parityerr} = f;
    rx_rxrdy = 1'b1;
    if (clr_cap) begin
      clear_model();
    end else begin
      m_par = sat(m_par + int'(f[0]));
      m_fra = sat(m_fra + int'(f[1]));
      m_ovr = sat(m_ovr + int'(f[2]));
    end
    if (occ >= DEPTH && !m_ready) begin
      if (!clr_cap) m_drop = sat(m_drop + 1);
    end else begin
      exp_q.push_back({f, d});
    end
    lat = 0;
    while (lat < 20) begin
      @(negedge mclkx16);
      lat++;
      clr_cnt = clr_cap && (lat == 1);
      if (rx_read === 1'b0) break;
    end
    clr_cnt = 1'b0;
    check("ack_latency", lat, 2);
    low_cycles = (rx_read === 1'b0) ? 1 : 0;
    if (!ignore_read) rx_rxrdy = 1'b0;
    for (int i = 0; i < ACK_TIMEOUT + 8 && rx_read !== 1'b1; i++) begin
      @(negedge mclkx16);
      if (rx_read === 1'b0) low_cycles++;
    end
    rx_rxrdy = 1'b0;
    {rx_overrun, rx_framingerr, rx_parityerr} = 3'b000;
    check("ack_release", rx_read, 1);
  endtask

  task automatic drain();
    @(negedge mclkx16);
    m_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH + 8 && m_valid === 1'b1; i++) @(negedge mclkx16);
    m_ready = 1'b0;
    check("drain_valid", m_valid, 0);
    check("drain_count", fifo_count, 0);
    check("pop_total", pop_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pop_log.size(); i++)
      check($sformatf("pop_entry%0d", i), pop_log[i], exp_q[i]);
    exp_q.delete();
    pop_log.delete();
  endtask

  initial begin
    int low;
    int n;
    reset = 1'b0; enable = 1'b1; rx_rdata = '0; rx_rxrdy = 1'b0;
    rx_parityerr = 1'b0; rx_framingerr = 1'b0; rx_overrun = 1'b0;
    m_ready = 1'b0; clr_cnt = 1'b0;
    clear_model();

    repeat (3) @(negedge mclkx16);
    check("rst_rx_read", rx_read, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_err", m_err, 0);
    check_cnt("rst");
    reset = 1'b1;

    // Single good frame with consumer ready
    m_ready = 1'b1;
    send(8'h0F, 3'b000, 1'b0, 1'b0, low);
    check("t1_low_in_range", (low >= 1 && low <= ACK_TIMEOUT), 1);
    @(negedge mclkx16);
    check("t1_pops", pop_log.size(), 1);
    check("t1_valid", m_valid, 0);
    m_ready = 1'b0;
    drain();
    check_cnt("t1");

    // Four frames queued behind a stalled consumer
    for (int i = 0; i < 4; i++) send(8'h0F, 3'b000, 1'b0, 1'b0, low);
    check("t2_count", fifo_count, 4);
    check("t2_valid", m_valid, 1);
    drain();

    // Overflow: DEPTH+2 frames, two dropped
    for (int i = 0; i < DEPTH + 2; i++) send(8'($urandom), 3'($urandom), 1'b0, 1'b0, low);
    check("t3_count", fifo_count, DEPTH);
    check_cnt("t3");
    drain();

    // Framing error on the middle of three frames
    for (int i = 0; i < 3; i++) send(8'($urandom), (i == 1) ? 3'b010 : 3'b000, 1'b0, 1'b0, low);
    check_cnt("t4");
    drain();

    // enable low: rxrdy must not be acknowledged
    enable = 1'b0;
    rx_rxrdy = 1'b1;
    repeat (6) @(negedge mclkx16);
    check("t5_no_ack", rx_read, 1);
    check("t5_no_push", fifo_count, 0);
    rx_rxrdy = 1'b0;
    enable = 1'b1;

    // Random bursts of random length
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, DEPTH + 3);
      for (int i = 0; i < n; i++) send(8'($urandom), 3'($urandom), 1'b0, 1'b0, low);
      check("t6_count", fifo_count, (n > DEPTH) ? DEPTH : n);
      check_cnt("t6");
      drain();
    end

    // clr_cnt coinciding with a capture wins over the increments
    send(8'hA5, 3'b111, 1'b0, 1'b1, low);
    check_cnt("t7");
    drain();

    // rxrdy stuck high: ACK aborts after ACK_TIMEOUT cycles
    send(8'h3C, 3'b000, 1'b1, 1'b0, low);
    m_tmo = 1;
    check("t8_low_cycles", low, ACK_TIMEOUT);
    check("t8_timeout", ack_timeout, 1);
    send(8'h5A, 3'b000, 1'b0, 1'b0, low);
    check("t8_count", fifo_count, 2);
    @(negedge mclkx16) clr_cnt = 1'b1;
    @(negedge mclkx16) clr_cnt = 1'b0;
    clear_model();
    check_cnt("t8_clr");
    drain();

    // Parity counter saturation with consumer ready
    m_ready = 1'b1;
    for (int i = 0; i < CNT_MAX + 3; i++) send(8'($urandom), 3'b001, 1'b0, 1'b0, low);
    m_ready = 1'b0;
    check("t9_sat", cnt_parity, CNT_MAX);
    check_cnt("t9");
    drain();

    // Asynchronous reset in the middle of an ACK
    @(negedge mclkx16);
    rx_rdata = 8'hC3;
    rx_rxrdy = 1'b1;
    for (int i = 0; i < 20 && rx_read !== 1'b0; i++) @(negedge mclkx16);
    check("t10_in_ack", rx_read, 0);
    #2 reset = 1'b0;
    #1;
    check("t10_rx_read_async", rx_read, 1);
    check("t10_count_async", fifo_count, 0);
    rx_rxrdy = 1'b0;
    exp_q.delete();
    pop_log.delete();
    clear_model();
    @(negedge mclkx16) reset = 1'b1;
    send(8'h96, 3'b100, 1'b0, 1'b0, low);
    check("t10_count", fifo_count, 1);
    check_cnt("t10");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
